// File: rtl/ax_bx_sequencer_pkg.sv
// Shared constants for the AX/BX register machine: default widths,
// opcode values and controller state encoding.
package ax_bx_sequencer_pkg;

    localparam int DATA_W_DEF = 3;
    localparam int ADDR_W_DEF = 4;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_MOVA = 4'b0001;
    localparam logic [3:0] OP_MOVB = 4'b0010;
    localparam logic [3:0] OP_XCHG = 4'b0011;
    localparam logic [3:0] OP_NOT  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;
    localparam logic [3:0] OP_ADD  = 4'b1000;
    localparam logic [3:0] OP_INC  = 4'b1001;
    localparam logic [3:0] OP_DEC  = 4'b1010;
    localparam logic [3:0] OP_JMP  = 4'b1011;
    localparam logic [3:0] OP_JZ   = 4'b1100;
    localparam logic [3:0] OP_HLT  = 4'b1111;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_EXEC  = 3'd2;
    localparam logic [2:0] ST_HALT  = 3'd3;
    localparam logic [2:0] ST_ERROR = 3'd4;

endpackage

// File: rtl/ax_bx_sequencer_if.sv
// Instruction-memory fetch bus: req/addr from the sequencer, ack/data back.
interface ax_bx_sequencer_if #(
    parameter int ADDR_W = 4
);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              ack;
    logic [ADDR_W+3:0] data;

    modport master (output req, addr, input ack, data);
    modport slave  (input req, addr, output ack, data);
endinterface

// File: rtl/ax_bx_sequencer_alu.sv
// Combinational per-opcode datapath for AX/BX. Branch, halt and NOP leave
// the registers untouched; the sequencer owns PC handling for those.
module ax_bx_alu
    import ax_bx_sequencer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [3:0]        opcode,
    input  logic [DATA_W-1:0] ax,
    input  logic [DATA_W-1:0] bx,
    input  logic [DATA_W-1:0] imm,
    output logic [DATA_W-1:0] next_ax,
    output logic [DATA_W-1:0] next_bx,
    output logic              zf_n,
    output logic              cf_n,
    output logic [1:0]        wr_flags,   // [0] writes zf, [1] writes cf
    output logic              illegal
);

    always_comb begin
        next_ax  = ax;
        next_bx  = bx;
        cf_n     = 1'b0;
        wr_flags = 2'b00;
        illegal  = 1'b0;
        case (opcode)
            OP_NOP, OP_JMP, OP_JZ, OP_HLT: ;
            OP_MOVA: begin next_ax = imm; wr_flags = 2'b01; end
            OP_MOVB: next_bx = imm;
            OP_XCHG: begin next_ax = bx; next_bx = ax; wr_flags = 2'b01; end
            OP_NOT:  begin next_ax = ~ax;     wr_flags = 2'b01; end
            OP_OR:   begin next_ax = ax | bx; wr_flags = 2'b01; end
            OP_XOR:  begin next_ax = ax ^ bx; wr_flags = 2'b01; end
            OP_AND:  begin next_ax = ax & bx; wr_flags = 2'b01; end
            OP_ADD: begin
                {cf_n, next_ax} = {1'b0, ax} + {1'b0, bx};
                wr_flags = 2'b11;
            end
            OP_INC: begin
                {cf_n, next_ax} = {1'b0, ax} + (DATA_W+1)'(1);
                wr_flags = 2'b11;
            end
            OP_DEC: begin
                // Borrow out of AX-1 happens exactly when AX was zero.
                cf_n     = (ax == '0);
                next_ax  = ax - DATA_W'(1);
                wr_flags = 2'b11;
            end
            default: illegal = 1'b1;
        endcase
        zf_n = (next_ax == '0);
    end

endmodule

// File: rtl/ax_bx_sequencer.sv
// Fetch/decode/execute controller: owns PC, IR, AX, BX and flags, fetches
// over the req/ack bus and retires one instruction per EXEC cycle.
module ax_bx_sequencer
    import ax_bx_sequencer_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int START_PC = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    ax_bx_sequencer_if.master  imem,
    output logic [DATA_W-1:0]  ax,
    output logic [DATA_W-1:0]  bx,
    output logic               zf,
    output logic               cf,
    output logic               busy,
    output logic               halted,
    output logic               err
);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q,    pc_d;
    logic [ADDR_W+3:0] ir_q,    ir_d;
    logic [DATA_W-1:0] ax_q,    ax_d;
    logic [DATA_W-1:0] bx_q,    bx_d;
    logic              zf_q,    zf_d;
    logic              cf_q,    cf_d;

    logic [3:0]        opcode;
    logic [ADDR_W-1:0] operand;
    logic [ADDR_W-1:0] pc_inc;
    logic [DATA_W-1:0] alu_ax, alu_bx;
    logic              alu_zf, alu_cf, alu_illegal;
    logic [1:0]        alu_wr;

    assign opcode  = ir_q[ADDR_W+3:ADDR_W];
    assign operand = ir_q[ADDR_W-1:0];
    assign pc_inc  = pc_q + ADDR_W'(1);

    ax_bx_alu #(.DATA_W(DATA_W)) u_alu (
        .opcode   (opcode),
        .ax       (ax_q),
        .bx       (bx_q),
        .imm      (operand[DATA_W-1:0]),
        .next_ax  (alu_ax),
        .next_bx  (alu_bx),
        .zf_n     (alu_zf),
        .cf_n     (alu_cf),
        .wr_flags (alu_wr),
        .illegal  (alu_illegal)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        ax_d    = ax_q;
        bx_d    = bx_q;
        zf_d    = zf_q;
        cf_d    = cf_q;
        case (state_q)
            ST_IDLE, ST_HALT, ST_ERROR: begin
                if (start) begin
                    state_d = ST_FETCH;
                    pc_d    = ADDR_W'(START_PC);
                end
            end
            ST_FETCH: begin
                if (imem.ack) begin
                    ir_d    = imem.data;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // Illegal opcodes and HLT freeze PC and registers in place.
                if (alu_illegal) begin
                    state_d = ST_ERROR;
                end else if (opcode == OP_HLT) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_FETCH;
                    ax_d    = alu_ax;
                    bx_d    = alu_bx;
                    if (alu_wr[0]) zf_d = alu_zf;
                    if (alu_wr[1]) cf_d = alu_cf;
                    case (opcode)
                        OP_JMP:  pc_d = operand;
                        OP_JZ:   pc_d = zf_q ? operand : pc_inc;
                        default: pc_d = pc_inc;
                    endcase
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= ADDR_W'(START_PC);
            ir_q    <= '0;
            ax_q    <= '0;
            bx_q    <= '0;
            zf_q    <= 1'b0;
            cf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            ax_q    <= ax_d;
            bx_q    <= bx_d;
            zf_q    <= zf_d;
            cf_q    <= cf_d;
        end
    end

    // req decodes straight from state so an async reset drops it at once.
    assign imem.req  = (state_q == ST_FETCH);
    assign imem.addr = pc_q;
    assign ax        = ax_q;
    assign bx        = bx_q;
    assign zf        = zf_q;
    assign cf        = cf_q;
    assign busy      = (state_q == ST_FETCH) || (state_q == ST_EXEC);
    assign halted    = (state_q == ST_HALT);
    assign err       = (state_q == ST_ERROR);

endmodule

// File: tb/tb_ax_bx_sequencer.sv
// Bench for ax_bx_sequencer: instruction-level reference model checked every
// cycle, plus directed programs with hand-computed final results.
module tb_ax_bx_sequencer;

    localparam int M_IDLE = 0, M_FETCH = 1, M_EXEC = 2, M_HALT = 3, M_ERR = 4;

    typedef struct {
        int         mode;
        int         pc;
        int         ax;
        int         bx;
        bit         zf;
        bit         cf;
        logic [7:0] ir;
    } mstate_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic force_ack = 1'b0;
    int   lat = 0;
    int   wait_cnt = 0;
    logic [7:0] mem [16];

    logic [2:0] ax, bx;
    logic zf, cf, busy, halted, err;

    int total = 0;
    int bad = 0;
    mstate_t m;

    ax_bx_sequencer_if #(.ADDR_W(4)) bus ();

    ax_bx_sequencer #(.DATA_W(3), .ADDR_W(4), .START_PC(0)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .imem   (bus.master),
        .ax     (ax),
        .bx     (bx),
        .zf     (zf),
        .cf     (cf),
        .busy   (busy),
        .halted (halted),
        .err    (err)
    );

    always #5 clk = ~clk;

    // Memory: ack arrives after `lat` extra req cycles; force_ack injects stray acks.
    assign bus.ack  = force_ack || (bus.req && (wait_cnt >= lat));
    assign bus.data = mem[bus.addr];

    always @(posedge clk) begin
        if (!bus.req || bus.ack) wait_cnt <= 0;
        else                     wait_cnt <= wait_cnt + 1;
    end

    function automatic mstate_t model_reset();
        mstate_t r;
        r.mode = M_IDLE; r.pc = 0; r.ax = 0; r.bx = 0;
        r.zf = 1'b0; r.cf = 1'b0; r.ir = 8'h00;
        return r;
    endfunction

    // One clock of the instruction-level machine.
    function automatic mstate_t step(mstate_t s, bit st, bit ack, logic [7:0] w);
        mstate_t n = s;
        int op, imm, d, t;
        case (s.mode)
            M_IDLE, M_HALT, M_ERR: if (st) begin n.mode = M_FETCH; n.pc = 0; end
            M_FETCH: if (ack) begin n.ir = w; n.mode = M_EXEC; end
            default: begin
                op = int'(s.ir[7:4]); imm = int'(s.ir[3:0]); d = imm % 8;
                n.mode = M_FETCH;
                n.pc = (s.pc + 1) % 16;
                case (op)
                    1:  n.ax = d;
                    2:  n.bx = d;
                    3:  begin n.ax = s.bx; n.bx = s.ax; end
                    4:  n.ax = 7 - s.ax;
                    5:  n.ax = s.ax | s.bx;
                    6:  n.ax = s.ax ^ s.bx;
                    7:  n.ax = s.ax & s.bx;
                    8:  begin t = s.ax + s.bx; n.cf = (t > 7); n.ax = t % 8; end
                    9:  begin t = s.ax + 1;    n.cf = (t > 7); n.ax = t % 8; end
                    10: begin n.cf = (s.ax == 0); n.ax = (s.ax + 7) % 8; end
                    11: n.pc = imm;
                    12: if (s.zf) n.pc = imm;
                    15: begin n.mode = M_HALT; n.pc = s.pc; end
                    13, 14: begin n.mode = M_ERR; n.pc = s.pc; end
                    default: ;
                endcase
                if (op == 1 || (op >= 3 && op <= 10)) n.zf = (n.ax == 0);
            end
        endcase
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m <= model_reset();
        else     m <= step(m, start, bus.ack, mem[m.pc]);
    end

    task automatic check(input string name, input int act, input int exp);
        total = total + 1;
        if (act != exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check("cyc_ax",     ax, m.ax);
            check("cyc_bx",     bx, m.bx);
            check("cyc_zf",     zf, m.zf);
            check("cyc_cf",     cf, m.cf);
            check("cyc_req",    bus.req, m.mode == M_FETCH);
            check("cyc_addr",   bus.addr, m.pc);
            check("cyc_busy",   busy, m.mode == M_FETCH || m.mode == M_EXEC);
            check("cyc_halted", halted, m.mode == M_HALT);
            check("cyc_err",    err, m.mode == M_ERR);
        end
    end

    function automatic logic [7:0] ins(input int op, input int imm);
        return {op[3:0], imm[3:0]};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // Halt must appear exactly n edges after the edge that sampled start.
    task automatic run_expect_halt(input string name, input int n);
        repeat (n - 1) @(posedge clk);
        #1 check({name, "_not_yet"}, halted, 0);
        @(posedge clk);
        #1 check({name, "_halted"}, halted, 1);
    endtask

    initial begin
        clear_mem();
        repeat (2) @(posedge clk);
        #1;
        check("rst_ax", ax, 0);
        check("rst_bx", bx, 0);
        check("rst_req", bus.req, 0);
        check("rst_busy", busy, 0);
        check("rst_flags", {zf, cf, halted, err}, 0);
        rst = 1'b0;

        // Basic run: 6 & 3 = 2.
        mem[0] = ins(1, 6); mem[1] = ins(2, 3); mem[2] = ins(7, 0); mem[3] = ins(15, 0);
        pulse_start();
        run_expect_halt("basic", 8);
        check("basic_ax", ax, 2);
        check("basic_bx", bx, 3);
        check("basic_zf", zf, 0);
        check("basic_pc", bus.addr, 3);

        // ADD 5+3 overflows to 0 with carry; rerun gives the same result.
        mem[0] = ins(1, 5); mem[2] = ins(8, 0);
        pulse_start();
        run_expect_halt("add", 8);
        check("add_ax", ax, 0);
        check("add_cf", cf, 1);
        check("add_zf", zf, 1);
        pulse_start();
        run_expect_halt("add_rerun", 8);
        check("add_rerun_ax", ax, 0);
        check("add_rerun_cf", cf, 1);

        // Slow memory on the basic program: 4 fetch + 1 exec per instruction.
        lat = 3;
        mem[0] = ins(1, 6); mem[2] = ins(7, 0);
        pulse_start();
        run_expect_halt("slow", 20);
        check("slow_ax", ax, 2);
        check("slow_bx", bx, 3);
        lat = 0;

        // Branches: JZ not taken, JZ taken to 15, NOP at 15 wraps to 0.
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        clear_mem();
        mem[0] = ins(12, 6); mem[1] = ins(1, 0); mem[2] = ins(12, 15);
        mem[15] = ins(0, 0); mem[6] = ins(2, 7); mem[7] = ins(15, 0);
        pulse_start();
        run_expect_halt("branch", 14);
        check("branch_ax", ax, 0);
        check("branch_bx", bx, 7);
        check("branch_zf", zf, 1);
        check("branch_pc", bus.addr, 7);

        // Illegal opcode at address 2.
        clear_mem();
        mem[0] = ins(1, 3); mem[1] = ins(2, 5); mem[2] = ins(13, 0);
        pulse_start();
        repeat (6) @(posedge clk);
        #1;
        check("ill_err", err, 1);
        check("ill_busy", busy, 0);
        check("ill_ax", ax, 3);
        check("ill_bx", bx, 5);
        check("ill_pc", bus.addr, 2);
        mem[2] = ins(15, 0);
        pulse_start();
        check("ill_clear_err", err, 0);
        check("ill_restart_pc", bus.addr, 0);
        run_expect_halt("ill_restart", 6);
        check("ill_restart_pc2", bus.addr, 2);

        // Async reset mid-FETCH with slow memory, then a stray late ack.
        lat = 3;
        pulse_start();
        check("ar_req_before", bus.req, 1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("ar_req", bus.req, 0);
        check("ar_ax", ax, 0);
        check("ar_bx", bx, 0);
        check("ar_busy", busy, 0);
        @(posedge clk); #1 rst = 1'b0; force_ack = 1'b1;
        repeat (2) @(posedge clk);
        #1 force_ack = 1'b0;
        check("ar_late_ack_busy", busy, 0);
        check("ar_late_ack_req", bus.req, 0);
        repeat (3) @(posedge clk);
        #1;
        check("ar_idle_busy", busy, 0);
        check("ar_idle_halted", halted, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ax_bx_sequencer.md
Name: ax_bx_sequencer

Overview:
- Fetch/decode/execute controller for the 3-bit AX/BX register machine.
- Owns the AX and BX registers and the program counter.
- Fetches opcode+operand words from an instruction memory over a req/ack handshake.
- Sequences the combinational ALU sub-module one instruction per execute cycle. It is the control layer above the per-opcode datapath logic (e.g. AND AX,BX on opcode 4'b0111).

Parameters:
- DATA_W, 3, width of AX, BX and of immediate data.
- ADDR_W, 4, PC/instruction address width; instruction word is 4+ADDR_W bits.
- START_PC, 0, PC value loaded on reset and on start.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins execution from START_PC when not busy.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  ADDR_W  fetch address (= PC).
- imem_ack  in  1  fetch data valid this cycle.
- imem_data  in  4+ADDR_W  instruction: [ADDR_W+3:ADDR_W] opcode, [ADDR_W-1:0] operand.
- ax  out  DATA_W  AX register.
- bx  out  DATA_W  BX register.
- zf  out  1  zero flag (AX==0 after last ALU op).
- cf  out  1  carry out of last ADD/INC, borrow of DEC.
- busy  out  1  high in FETCH or EXEC.
- halted  out  1  high in HALT.
- err  out  1  high in ERROR (illegal opcode).

Behaviour:
- Reset (async, immediate): state=IDLE, PC=START_PC, ax=bx=0, zf=0, cf=0, imem_req=0, busy/halted/err=0.
- States: IDLE, FETCH, EXEC, HALT, ERROR.
- IDLE/HALT/ERROR + start=1 → FETCH, with PC=START_PC. AX, BX and flags are kept; halted and err clear. start in FETCH/EXEC is ignored.
- FETCH behaviour:
  - imem_req=1 and imem_addr=PC, both held stable until the cycle imem_ack=1.
  - On that edge: latch imem_data into IR, deassert req, go to EXEC.
  - Minimum fetch = 1 cycle (ack in the first req cycle). No timeout.
  - imem_ack while req=0 is ignored.
- EXEC: exactly one cycle. AX/BX/flags/PC update at the end of EXEC, then → FETCH. Minimum throughput = 1 instruction per 2 cycles.
- Opcodes (operand = imm; data ops use imm[DATA_W-1:0]):
  - 0000 NOP.
  - 0001 MOV AX,imm; 0010 MOV BX,imm; 0011 XCHG AX,BX.
  - 0100 NOT AX; 0101 OR AX,BX; 0110 XOR AX,BX; 0111 AND AX,BX.
  - 1000 ADD AX,BX: AX=(AX+BX) mod 2^DATA_W, cf=carry.
  - 1001 INC AX: cf=carry. 1010 DEC AX: cf=borrow.
  - 1011 JMP imm: PC=imm. 1100 JZ imm: PC=imm if zf=1, else PC+1.
  - 1111 HLT: → HALT, PC not advanced.
  - 1101, 1110: illegal → ERROR; registers and PC unchanged.
- zf updates only on AX-writing ALU ops (0001, 0011, 0100-1010).
- cf updates only on 1000-1010.
- PC increments mod 2^ADDR_W; 2^ADDR_W-1 wraps to 0.
- BX is written only by 0010 and 0011.
- Reset during FETCH: imem_req drops asynchronously; any in-flight ack after reset is ignored (state IDLE).

Decomposition:
- Shared package:
  - opcode localparams OP_NOP…OP_HLT;
  - state encoding ST_IDLE…ST_ERROR;
  - DATA_W/ADDR_W defaults.
- One sub-module: ax_bx_alu.
  - Combinational. Inputs: opcode, ax, bx, imm.
  - Outputs: next_ax, next_bx, zf_n, cf_n, wr_flags, illegal.
- The sequencer holds the FSM, PC, IR and registers only.

Test Plan:
- Basic run. Program MOV AX,6; MOV BX,3; AND AX,BX; HLT, with ack in the first req cycle → ax=2, bx=3, zf=0, halted=1 after 8 cycles; PC=3.
- ADD carry and zero. MOV AX,5; MOV BX,3; ADD; HLT → ax=0, cf=1, zf=1. Then start → re-runs from PC 0 with the same result.
- Slow memory. ack delayed 3 cycles per fetch → imem_req/imem_addr held stable throughout; 4 fetch cycles + 1 exec per instruction; results identical to the fast-memory run.
- Branch and wrap. JZ taken/not taken with a target at 15. A NOP at address 15 → next fetch address 0.
- Illegal opcode 1101 at address 2 → err=1 and busy=0; ax, bx and PC=2 unchanged; start clears err and restarts at 0.
- Async reset asserted mid-FETCH with req=1 → imem_req=0 and ax=bx=0 before the next clock edge; a late ack is ignored; stays IDLE until start.
